pkt_send_scheduler: RTL and testbench

//  N-channel periodic packet-send scheduler driving the send_packet_N control conduits (cmd_send/start_ram_addr) of the

---
 rtl/pkt_send_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_pkt_send_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_send_scheduler.sv
// pkt_send_scheduler: N-channel periodic send scheduler with busy backpressure.
// Optional SEND_SCHED_EXCL_EN: at most one cmd_send bit high per cycle.
module pkt_send_scheduler #(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 25,
  parameter int CNT_W     = 32,
  parameter int PULSE_LEN = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       frame_len,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH*CNT_W-1:0]  ch_offset,
  input  logic [N_CH*ADDR_W-1:0] ch_addr,
  input  logic [N_CH-1:0]        tx_busy,
  input  logic                   clr_overrun,
  output logic [N_CH-1:0]        cmd_send,
  output logic [N_CH*ADDR_W-1:0] start_ram_addr,
  output logic                   frame_tick,
  output logic [N_CH-1:0]        overrun
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    PULSE = 2'd2
  } st_e;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_m1;
  logic              tick_q, tick_d;

  st_e               st_q   [N_CH];
  st_e               st_d   [N_CH];
  logic [PW-1:0]     pc_q   [N_CH];
  logic [PW-1:0]     pc_d   [N_CH];
  logic [ADDR_W-1:0] addr_q [N_CH];
  logic [ADDR_W-1:0] addr_d [N_CH];
  logic [N_CH-1:0]   qd_q, qd_d;
  logic [N_CH-1:0]   ovr_q, ovr_d;

  logic [N_CH-1:0]   act;
  logic [N_CH-1:0]   hit;
  logic [N_CH-1:0]   last;
  logic [N_CH-1:0]   ready;
  logic [N_CH-1:0]   grant;

  assign len_m1 = frame_len - CNT_W'(1);

  // Frame counter: wraps at frame_len-1, tick the cycle after the wrap.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == len_m1) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Per-channel trigger, pulse-end and start-readiness terms.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      act[i]   = enable & ch_en[i];
      hit[i]   = act[i] &
                 (cnt_q == ch_offset[i*CNT_W +: CNT_W]);
      last[i]  = (st_q[i] == PULSE) &&
                 (pc_q[i] == PW'(PULSE_LEN - 1));
      ready[i] = act[i] & ~tx_busy[i] &
                 (((st_q[i] == IDLE) & hit[i]) |
                  (st_q[i] == PEND));
    end
  end

`ifdef SEND_SCHED_EXCL_EN
  // Start arbitration: no start while a pulse continues; lowest index wins.
  always_comb begin
    logic hold_any;
    logic taken;
    hold_any = 1'b0;
    taken    = 1'b0;
    grant    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((st_q[i] == PULSE) && !last[i]) hold_any = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) begin
      grant[i] = ready[i] & ~hold_any & ~taken;
      taken    = taken | grant[i];
    end
  end
`else
  assign grant = ready;
`endif

  // Channel FSM next state, pending/overrun tracking and address latch.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      pc_d[i]   = pc_q[i];
      addr_d[i] = addr_q[i];
      qd_d[i]   = qd_q[i];
      ovr_d[i]  = ovr_q[i] & ~clr_overrun;
      unique case (st_q[i])
        IDLE: begin
          if (hit[i]) begin
            if (grant[i]) begin
              st_d[i]   = PULSE;
              pc_d[i]   = '0;
              addr_d[i] = ch_addr[i*ADDR_W +: ADDR_W];
            end else begin
              st_d[i] = PEND;
            end
          end
        end
        PEND: begin
          if (!act[i]) begin
            st_d[i] = IDLE;
          end else begin
            if (hit[i]) ovr_d[i] = 1'b1;
            if (grant[i]) begin
              st_d[i]   = PULSE;
              pc_d[i]   = '0;
              addr_d[i] = ch_addr[i*ADDR_W +: ADDR_W];
            end
          end
        end
        PULSE: begin
          logic q;
          q       = qd_q[i];
          pc_d[i] = pc_q[i] + PW'(1);
          if (hit[i]) begin
            if (q) ovr_d[i] = 1'b1;
            q = 1'b1;
          end
          if (!act[i]) q = 1'b0;
          qd_d[i] = q;
          if (last[i]) begin
            pc_d[i] = '0;
            qd_d[i] = 1'b0;
            st_d[i] = q ? PEND : IDLE;
          end
        end
        default: begin
          st_d[i] = IDLE;
          qd_d[i] = 1'b0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      qd_q   <= '0;
      ovr_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= IDLE;
        pc_q[i]   <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      qd_q   <= qd_d;
      ovr_q  <= ovr_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= st_d[i];
        pc_q[i]   <= pc_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  // Output mapping.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cmd_send[i] = (st_q[i] == PULSE);
      start_ram_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end

  assign frame_tick = tick_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// tb_pkt_send_scheduler: randomized + directed bench with a cycle-level model.
// Model tracks remaining pulse cycles and a pending flag per channel.
module tb_pkt_send_scheduler;

  localparam int N  = 2;
  localparam int AW = 25;
  localparam int CW = 32;
  localparam int PL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] frame_len = '0;
  logic [N-1:0]  ch_en = '0;
  logic [N*CW-1:0] ch_offset = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N-1:0]  tx_busy = '0;
  logic          clr_overrun = 1'b0;
  logic [N-1:0]  cmd_send;
  logic [N*AW-1:0] start_ram_addr;
  logic          frame_tick;
  logic [N-1:0]  overrun;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  logic [CW-1:0] m_cnt;
  bit            m_tick;
  int            m_left [N];
  bit            m_wait [N];
  bit            m_ovr  [N];
  logic [AW-1:0] m_addr [N];
  logic [N-1:0]  e_cmd, e_ovr;
  logic [N*AW-1:0] e_addr;

  pkt_send_scheduler #(
    .N_CH(N), .ADDR_W(AW), .CNT_W(CW), .PULSE_LEN(PL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .frame_len(frame_len), .ch_en(ch_en),
    .ch_offset(ch_offset), .ch_addr(ch_addr),
    .tx_busy(tx_busy), .clr_overrun(clr_overrun),
    .cmd_send(cmd_send), .start_ram_addr(start_ram_addr),
    .frame_tick(frame_tick), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic pack_exp();
    for (int i = 0; i < N; i++) begin
      e_cmd[i] = (m_left[i] > 0);
      e_ovr[i] = m_ovr[i];
      e_addr[i*AW +: AW] = m_addr[i];
    end
  endtask

  task automatic model_reset();
    m_cnt = '0;
    m_tick = 0;
    for (int i = 0; i < N; i++) begin
      m_left[i] = 0; m_wait[i] = 0;
      m_ovr[i] = 0; m_addr[i] = '0;
    end
    pack_exp();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Advance one clock; inputs must already be applied.
  task automatic cyc();
    int nl [N]; bit nw [N]; bit no [N];
    logic [AW-1:0] na [N];
    bit a, h, want, hold, taken;
    logic [CW-1:0] lm1;
    hold = 0; taken = 0;
    for (int i = 0; i < N; i++) if (m_left[i] > 1) hold = 1;
    for (int i = 0; i < N; i++) begin
      a = enable && ch_en[i];
      h = a && (m_cnt == ch_offset[i*CW +: CW]);
      nl[i] = m_left[i]; nw[i] = m_wait[i];
      no[i] = m_ovr[i] && !clr_overrun;
      na[i] = m_addr[i];
      if (m_left[i] > 0) begin
        if (h) begin
          if (m_wait[i]) no[i] = 1;
          nw[i] = 1;
        end
        nl[i] = m_left[i] - 1;
      end else if (a && (h || m_wait[i])) begin
        if (m_wait[i] && h) no[i] = 1;
        want = !tx_busy[i];
`ifdef SEND_SCHED_EXCL_EN
        if (hold || taken) want = 0;
`endif
        if (want) begin
          nl[i] = PL; nw[i] = 0; taken = 1;
          na[i] = ch_addr[i*AW +: AW];
        end else begin
          nw[i] = 1;
        end
      end
      if (!a) nw[i] = 0;
    end
    lm1 = frame_len - 32'd1;
    @(posedge clk);
    m_tick = enable && (m_cnt == lm1);
    if (!enable || m_cnt == lm1) m_cnt = '0;
    else m_cnt = m_cnt + 32'd1;
    for (int i = 0; i < N; i++) begin
      m_left[i] = nl[i]; m_wait[i] = nw[i];
      m_ovr[i] = no[i]; m_addr[i] = na[i];
    end
    pack_exp();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic test_reset();
    do_reset();
    frame_len = 100; ch_offset = {32'd50, 32'd2};
    ch_addr = {25'h0, 25'h7}; ch_en = 2'b01; enable = 1;
    for (int k = 0; k < 4; k++) cyc();
    total++;
    if (cmd_send[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre cmd=%b want=1", cmd_send[0]);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({cmd_send, start_ram_addr, frame_tick, overrun} !== '0) begin
      bad++;
      $display("FAIL rst_async cmd=%b addr=%h tick=%b ovr=%b want 0",
        cmd_send, start_ram_addr, frame_tick, overrun);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total++;
      if (cmd_send[0] !== (k >= 3 && k <= 5)) begin
        bad++;
        $display("FAIL rst_restart k=%0d cmd=%b want=%b",
          k, cmd_send[0], (k >= 3 && k <= 5));
      end
    end
  endtask

  task automatic test_basic();
    int r0, r1, tk, lt;
    logic [N-1:0] pc;
    do_reset();
    frame_len = 100; ch_offset = {32'd20, 32'd10};
    ch_addr = {25'h40, 25'h1}; ch_en = 2'b11;
    tx_busy = 0; enable = 1;
    r0 = 0; r1 = 0; tk = 0; lt = -1; pc = 0;
    for (int k = 0; k < 210; k++) begin
      cyc();
      total++;
      if (cmd_send !== e_cmd || overrun !== e_ovr ||
          frame_tick !== m_tick || start_ram_addr !== e_addr) begin
        bad++;
        $display("FAIL basic c=%0d cmd=%b/%b ovr=%b/%b tk=%b/%b a=%h/%h",
          cyc_n, cmd_send, e_cmd, overrun, e_ovr, frame_tick, m_tick,
          start_ram_addr, e_addr);
      end
      if (cmd_send[0] && !pc[0]) begin
        r0++; total++;
        if (m_cnt != 11 || start_ram_addr[AW-1:0] !== 25'h1) begin
          bad++;
          $display("FAIL basic_ch0 cnt=%0d addr=%h want 11/1",
            m_cnt, start_ram_addr[AW-1:0]);
        end
      end
      if (cmd_send[1] && !pc[1]) begin
        r1++; total++;
        if (m_cnt != 21 || start_ram_addr[2*AW-1:AW] !== 25'h40) begin
          bad++;
          $display("FAIL basic_ch1 cnt=%0d addr=%h want 21/40",
            m_cnt, start_ram_addr[2*AW-1:AW]);
        end
      end
      if (frame_tick) begin
        tk++;
        if (lt >= 0) begin
          total++;
          if (cyc_n - lt != 100) begin
            bad++;
            $display("FAIL basic_tick period=%0d want 100", cyc_n - lt);
          end
        end
        lt = cyc_n;
      end
      pc = cmd_send;
    end
    total++;
    if (r0 != 2 || r1 != 2 || tk != 2) begin
      bad++;
      $display("FAIL basic_count r0=%0d r1=%0d tk=%0d want 2/2/2",
        r0, r1, tk);
    end
  endtask

  task automatic test_backpressure();
    int rise;
    bit p;
    do_reset();
    frame_len = 100; ch_offset = {32'd90, 32'd10};
    ch_addr = {25'h0, 25'h5}; ch_en = 2'b01; enable = 1;
    rise = -1; p = 0;
    for (int k = 0; k < 60; k++) begin
      tx_busy[0] = (m_cnt >= 5 && m_cnt <= 30);
      cyc();
      total++;
      if (cmd_send !== e_cmd || overrun !== e_ovr ||
          frame_tick !== m_tick || start_ram_addr !== e_addr) begin
        bad++;
        $display("FAIL bp c=%0d cmd=%b/%b ovr=%b/%b tk=%b/%b a=%h/%h",
          cyc_n, cmd_send, e_cmd, overrun, e_ovr, frame_tick, m_tick,
          start_ram_addr, e_addr);
      end
      if (cmd_send[0] && !p && rise < 0) rise = int'(m_cnt);
      p = cmd_send[0];
    end
    tx_busy = 0;
    total++;
    if (rise != 32 || overrun[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_rise cnt=%0d ovr=%b want 32/0", rise, overrun[0]);
    end
  endtask

  task automatic test_overrun();
    int rise;
    bit p;
    do_reset();
    frame_len = 8; ch_offset = {32'd90, 32'd0};
    ch_addr = {25'h0, 25'h9}; ch_en = 2'b01; enable = 1;
    rise = -1; p = 0;
    for (int k = 0; k < 40; k++) begin
      tx_busy[0] = (k < 20);
      clr_overrun = (k == 19);
      cyc();
      total++;
      if (cmd_send !== e_cmd || overrun !== e_ovr ||
          frame_tick !== m_tick || start_ram_addr !== e_addr) begin
        bad++;
        $display("FAIL ovr c=%0d cmd=%b/%b ovr=%b/%b tk=%b/%b a=%h/%h",
          cyc_n, cmd_send, e_cmd, overrun, e_ovr, frame_tick, m_tick,
          start_ram_addr, e_addr);
      end
      if (k == 18) begin
        total++;
        if (overrun[0] !== 1'b1) begin
          bad++;
          $display("FAIL ovr_set ovr=%b want 1", overrun[0]);
        end
      end
      if (k == 19) begin
        total++;
        if (overrun[0] !== 1'b0) begin
          bad++;
          $display("FAIL ovr_clr ovr=%b want 0", overrun[0]);
        end
      end
      if (cmd_send[0] && !p && rise < 0) rise = k + 1;
      p = cmd_send[0];
    end
    clr_overrun = 0; tx_busy = 0;
    total++;
    if (rise != 21) begin
      bad++;
      $display("FAIL ovr_fire cycle=%0d want 21", rise);
    end
  endtask

  task automatic test_enable_drop();
    int rise;
    do_reset();
    frame_len = 50; ch_offset = {32'd90, 32'd3};
    ch_addr = {25'h0, 25'h3}; ch_en = 2'b01;
    tx_busy = 2'b01; enable = 1;
    for (int k = 0; k < 10; k++) cyc();
    enable = 0; tx_busy = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      total++;
      if (cmd_send !== 2'b00 || frame_tick !== 1'b0) begin
        bad++;
        $display("FAIL en_drop cmd=%b tick=%b want 00/0",
          cmd_send, frame_tick);
      end
    end
    enable = 1; rise = -1;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      total++;
      if (cmd_send !== e_cmd || overrun !== e_ovr ||
          frame_tick !== m_tick || start_ram_addr !== e_addr) begin
        bad++;
        $display("FAIL en c=%0d cmd=%b/%b ovr=%b/%b tk=%b/%b a=%h/%h",
          cyc_n, cmd_send, e_cmd, overrun, e_ovr, frame_tick, m_tick,
          start_ram_addr, e_addr);
      end
      if (cmd_send[0] && rise < 0) rise = k;
      if (k == 50) begin
        total++;
        if (frame_tick !== 1'b1) begin
          bad++;
          $display("FAIL en_tick tick=%b want 1 at 50", frame_tick);
        end
      end
    end
    total++;
    if (rise != 4) begin
      bad++;
      $display("FAIL en_restart rise=%0d want 4", rise);
    end
  endtask

  task automatic test_simultaneous();
    int r0, r1, n0, n1;
    bit both;
    do_reset();
    frame_len = 100; ch_offset = {32'd10, 32'd10};
    ch_addr = {25'h22, 25'h11}; ch_en = 2'b11;
    tx_busy = 0; enable = 1;
    r0 = -1; r1 = -1; n0 = 0; n1 = 0; both = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      total++;
      if (cmd_send !== e_cmd || overrun !== e_ovr ||
          frame_tick !== m_tick || start_ram_addr !== e_addr) begin
        bad++;
        $display("FAIL sim c=%0d cmd=%b/%b ovr=%b/%b tk=%b/%b a=%h/%h",
          cyc_n, cmd_send, e_cmd, overrun, e_ovr, frame_tick, m_tick,
          start_ram_addr, e_addr);
      end
      if (cmd_send[0]) begin
        n0++; if (r0 < 0) r0 = int'(m_cnt);
      end
      if (cmd_send[1]) begin
        n1++; if (r1 < 0) r1 = int'(m_cnt);
      end
      if (cmd_send == 2'b11) both = 1;
    end
    total++;
`ifdef SEND_SCHED_EXCL_EN
    if (r0 != 11 || r1 != 14 || n0 != 3 || n1 != 3 || both) begin
      bad++;
      $display("FAIL excl r0=%0d r1=%0d n=%0d/%0d both=%b want 11/14/3/3/0",
        r0, r1, n0, n1, both);
    end
`else
    if (r0 != 11 || r1 != 11 || n0 != 3 || n1 != 3) begin
      bad++;
      $display("FAIL par r0=%0d r1=%0d n=%0d/%0d want 11/11/3/3",
        r0, r1, n0, n1);
    end
`endif
  endtask

  task automatic test_random();
    logic [CW-1:0] fl;
    do_reset();
    enable = 1; ch_en = 2'b11; tx_busy = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        fl = $urandom_range(20, 3);
        frame_len = fl;
        for (int i = 0; i < N; i++)
          ch_offset[i*CW +: CW] = $urandom_range(fl + 1, 0);
      end
      if ($urandom_range(7, 0) == 0)
        for (int i = 0; i < N; i++)
          ch_addr[i*AW +: AW] = AW'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5, 0) == 0) tx_busy[i] = ~tx_busy[i];
        if ($urandom_range(99, 0) == 0) ch_en[i] = ~ch_en[i];
      end
      if (enable && $urandom_range(149, 0) == 0) enable = 0;
      else if (!enable && $urandom_range(9, 0) == 0) enable = 1;
      clr_overrun = ($urandom_range(29, 0) == 0);
      cyc();
      total++;
      if (cmd_send !== e_cmd || overrun !== e_ovr ||
          frame_tick !== m_tick || start_ram_addr !== e_addr) begin
        bad++;
        $display("FAIL rand c=%0d cmd=%b/%b ovr=%b/%b tk=%b/%b a=%h/%h",
          cyc_n, cmd_send, e_cmd, overrun, e_ovr, frame_tick, m_tick,
          start_ram_addr, e_addr);
      end
    end
    clr_overrun = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_enable_drop();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
